control_issue_queue: RTL and testbench
======================================

Name: control_issue_queue

Overview:
- Parametrised in-order decode/issue stage placed between fetch and execute.
- Buffers up to DEPTH fetched 32-bit MIPS instructions and decodes each at enqueue into operand count, source registers, destination register and memory class.
- Issues the head entry only when its source and destination registers are free in an internal busy-bit scoreboard; writeback clears busy bits.
- Adds queueing, hazard interlock, flush and stall accounting on top of the single-cycle operand-count decode.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; acts at a clock edge while 0.
- in_valid  input  1  fetch presents in_instr.
- in_ready  output  1  queue accepts this cycle.
- in_instr  input  32  instruction word.
- flush  input  1  discard all queued entries.
- wb_valid  input  1  a writeback completes this cycle.
- wb_reg  input  5  register written back.
- issue_valid  output  1  head entry is issuable.
- issue_ready  input  1  execute accepts the head entry.
- issue_instr  output  32  head instruction word.
- issue_numop  output  2  number of register source operands: 0, 1 or 2.
- issue_dest  output  5  destination register; 0 if none.
- issue_load  output  1  head is lw.
- issue_store  output  1  head is sw.
- issue_illegal  output  1  head opcode/funct not in the decode table.
- stall_cycles  output  CNT_W  count of cycles the head was blocked by a hazard.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Decode table. rs = instr[25:21], rt = [20:16], rd = [15:11]. Decode happens at enqueue and is stored per entry.
  - op 000000, fn in {000100, 000110, 000111, 011000, 100000–100111}: numop 2 (rs, rt), dest rd.
  - op 000000, fn 001000 (jr): numop 1 (rs), no dest.
  - op 000010 (j): numop 0, no dest.
  - op 000100 / 000101: numop 2 (rs, rt), no dest.
  - op 000110 / 000111: numop 1 (rs), no dest.
  - op 001000, 001001, 001100, 001101, 001110: numop 1 (rs), dest rt.
  - op 100011: numop 1 (rs), dest rt, load.
  - op 101011: numop 2 (rs, rt), no dest, store.
  - Anything else: numop 0, no dest, illegal = 1. Illegal entries still issue normally; trapping is the consumer's job.
- Storage: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits; pointers wrap modulo DEPTH.
- Enqueue: in_ready = reset high & count < DEPTH & !flush.
  - Enqueue occurs when in_valid & in_ready.
  - There is no same-cycle pass-through when full.
  - An entry enqueued at edge t can issue no earlier than the cycle after t.
- Scoreboard: busy[31:0]; bit 0 is hard-wired to 0.
  - Effective busy = busy with bit wb_reg cleared when wb_valid (same-cycle writeback bypass).
  - hazard = count > 0 and (numop ≥ 1 and effective busy[rs]) or (numop = 2 and effective busy[rt]) or (dest ≠ 0 and effective busy[dest]).
- Issue:
  - issue_valid = count > 0 & !hazard & !flush; issue outputs are combinational from the head entry.
  - Fire = issue_valid & issue_ready. On fire: rd_ptr++ and busy[dest] is set if dest ≠ 0.
  - If the same register is set on issue and cleared by wb in one cycle, the set wins.
  - Simultaneous enqueue and fire leaves count unchanged.
- stall_cycles increments when count > 0 & hazard & !flush, and saturates at all-ones.
  - A cycle with issue_valid high but issue_ready low does not count as a stall.
- Flush: at the edge, count, rd_ptr and wr_ptr go to 0; enqueue and issue are suppressed that cycle.
  - Busy bits are retained, because in-flight instructions still write back.
  - wb is processed normally during a flush.
- Writeback to a non-busy register, or to reg 0, has no effect.
- Reset (reset = 0 at an edge), including mid-operation:
  - count, pointers, busy and stall_cycles all go to 0.
  - While reset is low, in_ready = 0 and issue_valid = 0.
  - Entry contents need not be cleared.

Test Plan:
- Fill/drain: enqueue addu $3,$1,$2 ×4 with issue_ready = 0 → count = 4, in_ready = 0. Then issue_ready = 1 → the first entry issues with numop 2, dest 3.
- RAW interlock: lw $5,0($1) then add $6,$5,$5, no wb.
  - lw issues, busy[5] set; add is blocked and stall_cycles counts 1, 2, 3.
  - wb_valid with wb_reg 5 → add issues in that same cycle.
- WAW plus reg 0: addi $0,$1,4 issues with no busy set. Then addi $7 twice → the second waits for wb of 7.
- Wrap/simultaneous: DEPTH = 4; sustain one enqueue plus one fire per cycle for 10 instructions → count stays constant and issue order equals enqueue order across pointer wrap.
- Flush: 3 entries queued with busy[9] set → after the flush edge, count = 0 and issue_valid = 0. A later wb of 9 clears busy[9].
- Decode/reset: op 111111 → issue_illegal = 1, numop 0. Assert reset mid-stream → count = 0 and busy = 0 at the next edge, and in_ready = 0 while reset is low.

Source files
------------

// File: rtl/control_issue_queue.sv
// rtl/control_issue_queue.sv - in-order decode/issue queue with busy-bit scoreboard
// Decodes MIPS words at enqueue, interlocks the head on register hazards, counts stalls.
module control_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic                         flush,
  input  logic                         wb_valid,
  input  logic [4:0]                   wb_reg,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [31:0]                  issue_instr,
  output logic [1:0]                   issue_numop,
  output logic [4:0]                   issue_dest,
  output logic                         issue_load,
  output logic                         issue_store,
  output logic                         issue_illegal,
  output logic [CNT_W-1:0]             stall_cycles,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  numop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        load;
    logic        store;
    logic        illegal;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  entry_t      new_e;
  entry_t      head;
  logic [31:0] eff_busy;
  logic        hazard;
  logic        enq;
  logic        fire;
  logic [5:0]  op;
  logic [5:0]  fn;

  assign op = in_instr[31:26];
  assign fn = in_instr[5:0];

  always_comb begin
    new_e       = '0;
    new_e.instr = in_instr;
    new_e.rs    = in_instr[25:21];
    new_e.rt    = in_instr[20:16];
    case (op)
      6'b000000: begin
        if ((fn inside {6'b000100, 6'b000110, 6'b000111, 6'b011000}) || (fn[5:3] == 3'b100)) begin
          new_e.numop = 2'd2;
          new_e.dest  = in_instr[15:11];
        end else if (fn == 6'b001000) begin
          new_e.numop = 2'd1;
        end else begin
          new_e.illegal = 1'b1;
        end
      end
      6'b000010: new_e.numop = 2'd0;
      6'b000100, 6'b000101: new_e.numop = 2'd2;
      6'b000110, 6'b000111: new_e.numop = 2'd1;
      6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110: begin
        new_e.numop = 2'd1;
        new_e.dest  = in_instr[20:16];
      end
      6'b100011: begin
        new_e.numop = 2'd1;
        new_e.dest  = in_instr[20:16];
        new_e.load  = 1'b1;
      end
      6'b101011: begin
        new_e.numop = 2'd2;
        new_e.store = 1'b1;
      end
      default: new_e.illegal = 1'b1;
    endcase
  end

  assign head = mem_q[rd_ptr_q];

  // Writeback in the same cycle releases the register for the head immediately.
  always_comb begin
    eff_busy = busy_q;
    if (wb_valid) eff_busy[wb_reg] = 1'b0;
  end

  assign hazard = (count_q != '0) &&
                  (((head.numop != 2'd0) && eff_busy[head.rs]) ||
                   ((head.numop == 2'd2) && eff_busy[head.rt]) ||
                   ((head.dest != 5'd0) && eff_busy[head.dest]));

  assign in_ready    = reset && (count_q < CW'(DEPTH)) && !flush;
  assign issue_valid = reset && (count_q != '0) && !hazard && !flush;
  assign enq         = in_valid && in_ready;
  assign fire        = issue_valid && issue_ready;

  assign issue_instr   = head.instr;
  assign issue_numop   = head.numop;
  assign issue_dest    = head.dest;
  assign issue_load    = head.load;
  assign issue_store   = head.store;
  assign issue_illegal = head.illegal;
  assign stall_cycles  = stall_q;
  assign count         = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        mem_d[wr_ptr_q] = new_e;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (fire) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    if (hazard && !flush && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
  end

  // Issue-set is applied after writeback-clear so the set wins on a collision.
  always_comb begin
    busy_d = eff_busy;
    if (fire && (head.dest != 5'd0)) busy_d[head.dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      stall_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_control_issue_queue.sv
// tb/tb_control_issue_queue.sv - directed bench for control_issue_queue
// Decode table vectors plus hand-written hazard, wrap, flush and reset sequences.
module tb_control_issue_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [1:0]  issue_numop;
  logic [4:0]  issue_dest;
  logic        issue_load;
  logic        issue_store;
  logic        issue_illegal;
  logic [15:0] stall_cycles;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  control_issue_queue #(.DEPTH(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .wb_valid(wb_valid), .wb_reg(wb_reg),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_numop(issue_numop), .issue_dest(issue_dest), .issue_load(issue_load),
    .issue_store(issue_store), .issue_illegal(issue_illegal),
    .stall_cycles(stall_cycles), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  numop;
    logic [4:0]  dest;
    logic        load;
    logic        store;
    logic        illegal;
  } vec_t;

  vec_t vecs [13];

  localparam logic [31:0] ADDU3 = 32'h0022_1821;
  localparam logic [31:0] LW5   = 32'h8C25_0000;
  localparam logic [31:0] ADD6  = 32'h00A5_3020;
  localparam logic [31:0] ADDI0 = 32'h2020_0004;
  localparam logic [31:0] ADDI7 = 32'h2027_0004;
  localparam logic [31:0] ADDI9 = 32'h2029_0000;
  localparam logic [31:0] ADDI10_9 = 32'h212A_0000;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle;
    in_valid = 0; in_instr = 0; flush = 0; wb_valid = 0; wb_reg = 0; issue_ready = 0;
  endtask

  task automatic do_reset;
    idle();
    reset = 0;
    tick();
    reset = 1;
    #1;
  endtask

  initial begin
    vecs[0]  = '{ADDU3,        2'd2, 5'd3, 0, 0, 0};
    vecs[1]  = '{32'h03E00008, 2'd1, 5'd0, 0, 0, 0};
    vecs[2]  = '{32'h08000010, 2'd0, 5'd0, 0, 0, 0};
    vecs[3]  = '{32'h10220004, 2'd2, 5'd0, 0, 0, 0};
    vecs[4]  = '{32'h18800002, 2'd1, 5'd0, 0, 0, 0};
    vecs[5]  = '{ADDI7,        2'd1, 5'd7, 0, 0, 0};
    vecs[6]  = '{LW5,          2'd1, 5'd5, 1, 0, 0};
    vecs[7]  = '{32'hAC220008, 2'd2, 5'd0, 0, 1, 0};
    vecs[8]  = '{32'hFC000000, 2'd0, 5'd0, 0, 0, 1};
    vecs[9]  = '{32'h00000001, 2'd0, 5'd0, 0, 0, 1};
    vecs[10] = '{32'h00221804, 2'd2, 5'd3, 0, 0, 0};
    vecs[11] = '{32'h00220018, 2'd2, 5'd0, 0, 0, 0};
    vecs[12] = '{32'h34270001, 2'd1, 5'd7, 0, 0, 0};

    // reset behaviour
    idle();
    reset = 0;
    tick();
    chk("rst_in_ready_low", in_ready, 0);
    chk("rst_issue_valid_low", issue_valid, 0);
    reset = 1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_in_ready_high", in_ready, 1);

    // decode table
    for (int i = 0; i < 13; i++) begin
      in_valid = 1; in_instr = vecs[i].instr;
      tick();
      in_valid = 0;
      #1;
      chk($sformatf("dec%0d_count", i), count, 1);
      chk($sformatf("dec%0d_valid", i), issue_valid, 1);
      chk($sformatf("dec%0d_instr", i), issue_instr, vecs[i].instr);
      chk($sformatf("dec%0d_numop", i), issue_numop, vecs[i].numop);
      chk($sformatf("dec%0d_dest", i), issue_dest, vecs[i].dest);
      chk($sformatf("dec%0d_load", i), issue_load, vecs[i].load);
      chk($sformatf("dec%0d_store", i), issue_store, vecs[i].store);
      chk($sformatf("dec%0d_illegal", i), issue_illegal, vecs[i].illegal);
      flush = 1;
      tick();
      flush = 0;
    end

    // fill / drain
    do_reset();
    in_valid = 1; in_instr = ADDU3;
    repeat (5) tick();
    chk("fill_count", count, 4);
    chk("fill_in_ready", in_ready, 0);
    in_valid = 0; issue_ready = 1;
    #1;
    chk("drain_valid", issue_valid, 1);
    chk("drain_numop", issue_numop, 2);
    chk("drain_dest", issue_dest, 3);
    tick();
    chk("drain_count", count, 3);
    chk("drain_waw_block", issue_valid, 0);

    // RAW interlock
    do_reset();
    in_valid = 1; in_instr = LW5;
    tick();
    in_instr = ADD6;
    tick();
    in_valid = 0; issue_ready = 1;
    #1;
    chk("raw_lw_valid", issue_valid, 1);
    chk("raw_lw_load", issue_load, 1);
    tick();
    chk("raw_add_blocked", issue_valid, 0);
    chk("raw_stall0", stall_cycles, 0);
    for (int s = 1; s <= 3; s++) begin
      tick();
      chk($sformatf("raw_stall%0d", s), stall_cycles, s);
    end
    wb_valid = 1; wb_reg = 5;
    #1;
    chk("raw_bypass_valid", issue_valid, 1);
    chk("raw_bypass_dest", issue_dest, 6);
    tick();
    wb_valid = 0;
    #1;
    chk("raw_after_count", count, 0);
    chk("raw_after_stall", stall_cycles, 3);

    // WAW and reg 0
    do_reset();
    issue_ready = 1;
    in_valid = 1; in_instr = ADDI0;
    tick();
    in_instr = ADDI0;
    #1;
    chk("r0_first_valid", issue_valid, 1);
    tick();
    in_instr = ADDI7;
    #1;
    chk("r0_second_valid", issue_valid, 1);
    tick();
    in_instr = ADDI7;
    #1;
    chk("waw_first_valid", issue_valid, 1);
    chk("waw_first_dest", issue_dest, 7);
    tick();
    in_valid = 0;
    #1;
    chk("waw_second_blocked", issue_valid, 0);
    chk("waw_count", count, 1);
    tick();
    chk("waw_stall", stall_cycles, 1);
    wb_valid = 1; wb_reg = 7;
    #1;
    chk("waw_wb_valid", issue_valid, 1);
    tick();
    wb_valid = 0;
    #1;
    chk("waw_drained", count, 0);

    // wrap with simultaneous enqueue and fire
    do_reset();
    issue_ready = 1;
    in_valid = 1; in_instr = 32'h0800_0000;
    tick();
    for (int i = 1; i <= 10; i++) begin
      in_instr = 32'h0800_0000 | i;
      #1;
      chk($sformatf("wrap_order%0d", i), issue_instr, 32'h0800_0000 | (i - 1));
      tick();
      chk($sformatf("wrap_count%0d", i), count, 1);
    end
    in_valid = 0;
    #1;
    chk("wrap_last", issue_instr, 32'h0800_000A);
    tick();
    chk("wrap_empty", count, 0);

    // flush retains busy bits
    do_reset();
    issue_ready = 1;
    in_valid = 1; in_instr = ADDI9;
    tick();
    in_valid = 0;
    tick();
    issue_ready = 0;
    in_valid = 1; in_instr = 32'h0800_0001;
    repeat (3) tick();
    in_valid = 0;
    #1;
    chk("flush_pre_count", count, 3);
    flush = 1;
    #1;
    chk("flush_issue_valid", issue_valid, 0);
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 0;
    #1;
    chk("flush_count", count, 0);
    chk("flush_valid_after", issue_valid, 0);
    in_valid = 1; in_instr = ADDI10_9;
    tick();
    in_valid = 0;
    #1;
    chk("flush_busy9_kept", issue_valid, 0);
    wb_valid = 1; wb_reg = 9;
    tick();
    wb_valid = 0;
    #1;
    chk("flush_busy9_cleared", issue_valid, 1);

    // reset mid-stream
    do_reset();
    issue_ready = 1;
    in_valid = 1; in_instr = LW5;
    tick();
    in_instr = ADD6;
    tick();
    in_valid = 0;
    tick();
    tick();
    chk("mid_stall_pre", stall_cycles, 2);
    chk("mid_count_pre", count, 1);
    reset = 0;
    #1;
    chk("mid_in_ready_low", in_ready, 0);
    chk("mid_issue_valid_low", issue_valid, 0);
    tick();
    chk("mid_count", count, 0);
    chk("mid_stall", stall_cycles, 0);
    chk("mid_in_ready_still_low", in_ready, 0);
    reset = 1;
    in_valid = 1; in_instr = ADD6;
    tick();
    in_valid = 0;
    #1;
    chk("mid_busy_cleared", issue_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
